// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default sizing and
// the parity-type encoding used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_W_DEF     = 8;

  // parityType encoding on the framing interface
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Modulo-OVERSAMPLE bit timer. Counts 0..OVERSAMPLE-1 while en is high and
// flags the terminal count with tick; clear restarts the count at 0.
module tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] TERM = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == TERM);

  // Count clocks within the current bit, wrapping at the terminal count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TERM) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Oversampled UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity bit, stop bit; each bit lasts OVERSAMPLE clocks.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits.
//
// Handshake: start is a request that is accepted on a rising edge only when
// busy is 0; data_in/parity/parityType are captured on that edge. busy is
// high for exactly the frame cycles, and done pulses for one cycle right
// after the last stop cycle (busy already 0), so start may be raised in the
// done cycle to chain frames without a gap in the start-bit timing.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity,
  input  logic              parityType,
  output logic              out,
  output logic              busy,
  output logic              done,
  output tx_state_t         dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [DATA_W-1:0] data_q, data_q_n;
  logic              par_en_q, par_en_n;
  logic              par_type_q, par_type_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              out_n, busy_n, done_n;
  logic              accept;
  logic              tick;
`ifdef UART_TX_TWO_STOP_EN
  logic              stop2, stop2_n;
`endif

  assign accept    = start && !busy;
  assign dbg_state = state;

  tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Next-state, datapath updates and next line level for the frame FSM
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    data_q_n   = data_q;
    par_en_n   = par_en_q;
    par_type_n = par_type_q;
    idx_n      = idx;
    done_n     = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop2_n    = stop2;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n    = START;
          sh_n       = data_in;
          data_q_n   = data_in;
          par_en_n   = parity;
          par_type_n = parityType;
          idx_n      = '0;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          sh_n = sh >> 1;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        if (tick) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2) begin
            stop2_n = 1'b1;
          end else begin
            stop2_n = 1'b0;
            state_n = IDLE;
            done_n  = 1'b1;
          end
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // The line is registered, so it is derived from where the FSM is going
    case (state_n)
      START:   out_n = 1'b0;
      DATA:    out_n = sh_n[0];
      PARITY:  out_n = (^data_q_n) ^ par_type_n;
      default: out_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, datapath and registered outputs; reset abandons any frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PAR_EVEN;
      idx        <= '0;
      out        <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      data_q     <= data_q_n;
      par_en_q   <= par_en_n;
      par_type_q <= par_type_n;
      idx        <= idx_n;
      out        <= out_n;
      busy       <= busy_n;
      done       <= done_n;
`ifdef UART_TX_TWO_STOP_EN
      stop2      <= stop2_n;
`endif
    end
  end

endmodule
